mul8_share_ctrl: RTL and testbench

Sequencer that time-shares one combinational 8x8 approximate multiplier core among NREQ requesters. Requests are arbitrated round-robin, operands are registered into the core, and the product is captured after a fixed settle time. Results return on a single tagged valid/ready response port. The block sits between the accelerator's operand producers and the externally bound multiplier core (ports A, B, O), so any 8-bit multiplier variant can be swapped in at integration.

---
 rtl/mul8_pkg.sv | 15 +
 rtl/rr_arb.sv | 37 +++
 rtl/mul8_share_ctrl.sv | 146 ++++++++++++++
 tb/tb_mul8_share_ctrl.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul8_pkg.sv
// rtl/mul8_pkg.sv - shared widths, FSM states and settle-time limits for mul8_share_ctrl
package mul8_pkg;

  localparam int OP_W    = 8;
  localparam int PROD_W  = 16;
  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arb.sv
// rtl/rr_arb.sv - combinational round-robin arbiter, searches upward from ptr+1 with wrap
module rr_arb #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IDW-1:0]  i_ptr,
  input  logic            i_en,
  output logic [NREQ-1:0] o_gnt,
  output logic [IDW-1:0]  o_idx,
  output logic            o_any
);

  logic [IDW-1:0] w_cand;

  always_comb begin
    o_gnt  = '0;
    o_idx  = '0;
    o_any  = 1'b0;
    w_cand = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_cand = IDW'((int'(i_ptr) + k) % NREQ);
      if (!o_any && i_req[w_cand]) begin
        o_any = 1'b1;
        o_idx = w_cand;
      end
    end
    if (!i_en) begin
      o_any = 1'b0;
      o_idx = '0;
    end
    if (o_any) begin
      o_gnt[o_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/mul8_share_ctrl.sv
// rtl/mul8_share_ctrl.sv - time-shares one external 8x8 multiplier core among NREQ requesters
module mul8_share_ctrl
  import mul8_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int LAT         = 1,
  parameter int ZERO_BYPASS = 1,
  parameter int IDW         = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [OP_W*NREQ-1:0] req_a,
  input  logic [OP_W*NREQ-1:0] req_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [PROD_W-1:0]    rsp_p,
  output logic [OP_W-1:0]      core_a,
  output logic [OP_W-1:0]      core_b,
  input  logic [PROD_W-1:0]    core_o,
  output logic                 busy,
  output logic [PROD_W-1:0]    op_cnt
);

  localparam int CNT_W = $clog2(LAT_MAX + 1);

  state_t            r_state;
  state_t            w_next_state;
  logic [IDW-1:0]    r_ptr;
  logic [IDW-1:0]    r_rsp_id;
  logic [CNT_W-1:0]  r_cnt;
  logic [OP_W-1:0]   r_core_a;
  logic [OP_W-1:0]   r_core_b;
  logic [PROD_W-1:0] r_rsp_p;
  logic [PROD_W-1:0] r_op_cnt;
  logic [NREQ-1:0]   w_gnt;
  logic [IDW-1:0]    w_idx;
  logic              w_any;
  logic              w_arb_en;
  logic              w_bypass;
  logic [OP_W-1:0]   w_a;
  logic [OP_W-1:0]   w_b;

  // Grants only from IDLE and never while reset is asserted.
  assign w_arb_en = rst_n && (r_state == IDLE);

  rr_arb #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .i_req (req_valid),
    .i_ptr (r_ptr),
    .i_en  (w_arb_en),
    .o_gnt (w_gnt),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  always_comb begin
    w_a = '0;
    w_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_gnt[i]) begin
        w_a = req_a[i*OP_W +: OP_W];
        w_b = req_b[i*OP_W +: OP_W];
      end
    end
  end

  assign w_bypass = (ZERO_BYPASS != 0) && ((w_a == '0) || (w_b == '0));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: if (w_any) w_next_state = w_bypass ? HOLD : CALC;
      CALC: if (r_cnt == '0) w_next_state = HOLD;
      HOLD: if (rsp_ready) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    req_ready = w_gnt;
    rsp_valid = (r_state == HOLD);
    busy      = (r_state != IDLE);
  end

  // Core operands only move on a non-bypassed accept, so bypass leaves the core untouched.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr    <= IDW'(NREQ - 1);
      r_rsp_id <= '0;
      r_cnt    <= '0;
      r_core_a <= '0;
      r_core_b <= '0;
      r_rsp_p  <= '0;
      r_op_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_ptr    <= w_idx;
            r_rsp_id <= w_idx;
            if (w_bypass) begin
              r_rsp_p <= '0;
            end else begin
              r_core_a <= w_a;
              r_core_b <= w_b;
              r_cnt    <= CNT_W'(LAT - 1);
            end
          end
        end
        CALC: begin
          if (r_cnt == '0) begin
            r_rsp_p <= core_o;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        HOLD: begin
          if (rsp_ready) begin
            r_op_cnt <= r_op_cnt + PROD_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign rsp_id = r_rsp_id;
  assign rsp_p  = r_rsp_p;
  assign core_a = r_core_a;
  assign core_b = r_core_b;
  assign op_cnt = r_op_cnt;

endmodule

// File: tb/tb_mul8_share_ctrl.sv
// tb/tb_mul8_share_ctrl.sv - self-checking bench: two configurations against a transaction-level model
module tb_mul8_share_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        rsp_ready;

  logic [3:0]  d_ready [2];
  logic        d_valid [2];
  logic [1:0]  d_id    [2];
  logic [15:0] d_p     [2];
  logic [7:0]  d_ca    [2];
  logic [7:0]  d_cb    [2];
  logic [15:0] d_co    [2];
  logic        d_busy  [2];
  logic [15:0] d_cnt   [2];

  always #5 clk = ~clk;

  // Exact behavioural multiplier core bound at integration.
  assign d_co[0] = {8'd0, d_ca[0]} * {8'd0, d_cb[0]};
  assign d_co[1] = {8'd0, d_cb[1]} * {8'd0, d_ca[1]};

  mul8_share_ctrl #(.NREQ(4), .LAT(1), .ZERO_BYPASS(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(d_ready[0]),
    .req_a(req_a), .req_b(req_b), .rsp_valid(d_valid[0]), .rsp_ready(rsp_ready),
    .rsp_id(d_id[0]), .rsp_p(d_p[0]), .core_a(d_ca[0]), .core_b(d_cb[0]),
    .core_o(d_co[0]), .busy(d_busy[0]), .op_cnt(d_cnt[0])
  );

  mul8_share_ctrl #(.NREQ(4), .LAT(3), .ZERO_BYPASS(0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(d_ready[1]),
    .req_a(req_a), .req_b(req_b), .rsp_valid(d_valid[1]), .rsp_ready(rsp_ready),
    .rsp_id(d_id[1]), .rsp_p(d_p[1]), .core_a(d_ca[1]), .core_b(d_cb[1]),
    .core_o(d_co[1]), .busy(d_busy[1]), .op_cnt(d_cnt[1])
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit m_on  = 1'b0;

  // Model: one op in flight, response due a fixed number of edges after accept.
  bit          m_fl   [2];
  int          m_wait [2];
  int          m_ptr  [2];
  int          m_id   [2];
  logic [15:0] m_p    [2];
  logic [15:0] m_pend [2];
  logic [15:0] m_cnt  [2];
  logic [7:0]  m_ca   [2];
  logic [7:0]  m_cb   [2];
  int          g_log0 [$];
  int          g_log1 [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int pick(input int ptr, input logic [3:0] v);
    for (int i = 1; i <= 4; i++) begin
      if (v[(ptr + i) % 4]) return (ptr + i) % 4;
    end
    return 0;
  endfunction

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      int          g;
      logic [3:0]  e_rdy;
      logic [7:0]  oa;
      logic [7:0]  ob;
      g     = pick(m_ptr[k], req_valid);
      e_rdy = (!m_fl[k] && rst_n && (req_valid != 4'd0)) ? (4'd1 << g) : 4'd0;
      if (m_on) begin
        chk($sformatf("req_ready%0d", k), 32'(d_ready[k]), 32'(e_rdy));
        chk($sformatf("rsp_valid%0d", k), 32'(d_valid[k]), 32'(m_fl[k] && m_wait[k] == 0));
        chk($sformatf("busy%0d", k), 32'(d_busy[k]), 32'(m_fl[k]));
        chk($sformatf("rsp_id%0d", k), 32'(d_id[k]), 32'(m_id[k]));
        chk($sformatf("rsp_p%0d", k), 32'(d_p[k]), 32'(m_p[k]));
        chk($sformatf("core_a%0d", k), 32'(d_ca[k]), 32'(m_ca[k]));
        chk($sformatf("core_b%0d", k), 32'(d_cb[k]), 32'(m_cb[k]));
        chk($sformatf("op_cnt%0d", k), 32'(d_cnt[k]), 32'(m_cnt[k]));
      end
      if (!rst_n) begin
        m_fl[k] = 0; m_wait[k] = 0; m_ptr[k] = 3; m_id[k] = 0;
        m_p[k] = 0; m_pend[k] = 0; m_cnt[k] = 0; m_ca[k] = 0; m_cb[k] = 0;
      end else if (m_fl[k] && m_wait[k] == 0) begin
        if (rsp_ready) begin
          m_fl[k]  = 0;
          m_cnt[k] = m_cnt[k] + 16'd1;
        end
      end else if (m_fl[k]) begin
        m_wait[k]--;
        if (m_wait[k] == 0) m_p[k] = m_pend[k];
      end else if (req_valid != 4'd0) begin
        oa = req_a[g*8 +: 8];
        ob = req_b[g*8 +: 8];
        m_ptr[k] = g;
        m_id[k]  = g;
        m_fl[k]  = 1;
        if (k == 0) g_log0.push_back(g); else g_log1.push_back(g);
        if (k == 0 && (oa == 0 || ob == 0)) begin
          m_wait[k] = 0;
          m_p[k]    = 16'd0;
        end else begin
          m_ca[k]   = oa;
          m_cb[k]   = ob;
          m_wait[k] = lat_of(k);
          m_pend[k] = oa * ob;
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b);
    req_a[i*8 +: 8] = a;
    req_b[i*8 +: 8] = b;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = 4'd0;
    cyc(2);
    rst_n = 1'b1;
  endtask

  task automatic wait_quiet(input string nm);
    for (int i = 0; i < 100; i++) begin
      if (!d_busy[0] && !d_busy[1]) break;
      cyc(1);
    end
    chk(nm, {d_busy[0], d_busy[1]}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 4'd0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
    cyc(1);
    req_valid = 4'b1111;
    cyc(1);
    m_on = 1'b1;
    #1;
    chk("rst_no_grant", 32'(d_ready[0]), 32'd0);
    chk("rst_op_cnt", 32'(d_cnt[0]), 32'd0);
    do_reset();

    // Single op: requester 2, 13*11.
    set_op(2, 8'd13, 8'd11);
    req_valid = 4'b0100;
    #1;
    chk("t1_grant_same_cycle", 32'(d_ready[0]), 32'h4);
    cyc(1);
    req_valid = 4'd0;
    chk("t1_not_yet_valid", 32'(d_valid[0]), 32'd0);
    cyc(1);
    chk("t1_valid", 32'(d_valid[0]), 32'd1);
    chk("t1_id", 32'(d_id[0]), 32'd2);
    chk("t1_p", 32'(d_p[0]), 32'd143);
    cyc(1);
    chk("t1_op_cnt0", 32'(d_cnt[0]), 32'd1);
    cyc(2);
    chk("t1_op_cnt1", 32'(d_cnt[1]), 32'd1);
    wait_quiet("t1_quiet");

    // Round-robin with all requesters held.
    do_reset();
    g_log0.delete(); g_log1.delete();
    for (int i = 0; i < 4; i++) set_op(i, 8'(16 * i + 5), 8'(3 * i + 7));
    req_valid = 4'b1111;
    cyc(40);
    req_valid = 4'd0;
    wait_quiet("t2_quiet");
    chk("t2_ngrants", 32'(g_log0.size() >= 5 && g_log1.size() >= 5), 32'd1);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t2_order0_%0d", i), 32'(g_log0[i]), 32'(i % 4));
      chk($sformatf("t2_order1_%0d", i), 32'(g_log1[i]), 32'(i % 4));
    end

    // Zero bypass versus core path.
    do_reset();
    set_op(0, 8'd7, 8'd9);
    req_valid = 4'b0001;
    cyc(1);
    req_valid = 4'd0;
    wait_quiet("t3_quiet_a");
    set_op(0, 8'd0, 8'd200);
    req_valid = 4'b0001;
    cyc(1);
    req_valid = 4'd0;
    chk("t3_byp_valid", 32'(d_valid[0]), 32'd1);
    chk("t3_byp_p", 32'(d_p[0]), 32'd0);
    chk("t3_byp_core_a", 32'(d_ca[0]), 32'd7);
    chk("t3_byp_core_b", 32'(d_cb[0]), 32'd9);
    chk("t3_core_b1", 32'(d_cb[1]), 32'd200);
    chk("t3_valid1", 32'(d_valid[1]), 32'd0);
    wait_quiet("t3_quiet_b");
    chk("t3_op_cnt1", 32'(d_cnt[1]), 32'd2);

    // Back-pressure for 20 cycles.
    rsp_ready = 1'b0;
    set_op(1, 8'd25, 8'd4);
    set_op(0, 8'd3, 8'd3); set_op(2, 8'd6, 8'd6); set_op(3, 8'd9, 8'd2);
    req_valid = 4'b0010;
    cyc(1);
    req_valid = 4'b1111;
    cyc(20);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("t4_valid%0d", k), 32'(d_valid[k]), 32'd1);
      chk($sformatf("t4_p%0d", k), 32'(d_p[k]), 32'd100);
      chk($sformatf("t4_id%0d", k), 32'(d_id[k]), 32'd1);
      chk($sformatf("t4_ready%0d", k), 32'(d_ready[k]), 32'd0);
      chk($sformatf("t4_cnt%0d", k), 32'(d_cnt[k]), 32'd2);
    end
    rsp_ready = 1'b1;
    cyc(30);
    req_valid = 4'd0;
    wait_quiet("t4_quiet");

    // Reset while the LAT=3 instance is in CALC.
    set_op(0, 8'd3, 8'd5);
    req_valid = 4'b0001;
    cyc(1);
    req_valid = 4'd0;
    cyc(1);
    chk("t5_in_calc", 32'(d_busy[1] && !d_valid[1]), 32'd1);
    rst_n = 1'b0;
    req_valid = 4'b1111;
    cyc(1);
    chk("t5_rst_busy", 32'(d_busy[1]), 32'd0);
    chk("t5_rst_cnt", 32'(d_cnt[1]), 32'd0);
    chk("t5_rst_core_a", 32'(d_ca[1]), 32'd0);
    chk("t5_rst_ready", 32'(d_ready[1]), 32'd0);
    rst_n = 1'b1;
    set_op(1, 8'd4, 8'd4);
    req_valid = 4'b0011;
    #1;
    chk("t5_first_win0", 32'(d_ready[0]), 32'h1);
    chk("t5_first_win1", 32'(d_ready[1]), 32'h1);
    cyc(1);
    req_valid = 4'b0010;
    cyc(12);
    req_valid = 4'd0;
    wait_quiet("t5_quiet");

    // op_cnt wrap.
    force u_dut0.r_op_cnt = 16'hFFFF;
    force u_dut1.r_op_cnt = 16'hFFFF;
    m_cnt[0] = 16'hFFFF;
    m_cnt[1] = 16'hFFFF;
    #1;
    release u_dut0.r_op_cnt;
    release u_dut1.r_op_cnt;
    #1;
    chk("t6_preload", 32'(d_cnt[0]), 32'hFFFF);
    set_op(2, 8'd2, 8'd3);
    req_valid = 4'b0100;
    cyc(1);
    req_valid = 4'd0;
    wait_quiet("t6_quiet");
    chk("t6_wrap0", 32'(d_cnt[0]), 32'd0);
    chk("t6_wrap1", 32'(d_cnt[1]), 32'd0);
    cyc(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1);
  end

endmodule
